// File: rtl/imem_loadable.sv
// Loadable instruction memory: word-stream program loader (IDLE/LOAD/RUN) plus a
// registered, range/alignment-checked fetch port that returns NOP_WORD on fault.
module imem_loadable #(
   parameter int unsigned          DATA_W   = 32,
   parameter int unsigned          DEPTH    = 64,
   parameter logic [DATA_W-1:0]    NOP_WORD = DATA_W'(32'hE1A00000)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic              load_last,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   output logic              load_done,
   input  logic [31:0]       PC_Out,
   input  logic              fetch_en,
   output logic [DATA_W-1:0] theInstruction,
   output logic              inst_valid,
   output logic              fetch_fault
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned IDX_W = 30;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic                load_ready_q, load_ready_d;
   logic                load_done_q, load_done_d;
   logic                inst_valid_q, inst_valid_d;
   logic                fetch_fault_q, fetch_fault_d;
   logic [DATA_W-1:0]   instr_q, instr_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic                mem_we;
   logic [IDX_W-1:0]    pc_idx;
   logic [PTR_W-1:0]    rd_idx;
   logic                pc_bad;

   // Full-width range check so PCs at or above 4*DEPTH never alias low words.
   assign pc_idx = PC_Out[31:2];
   assign rd_idx = PC_Out[2 +: PTR_W];
   assign pc_bad = (PC_Out[1:0] != 2'b00) || (pc_idx >= IDX_W'(DEPTH));

   // Next-state and registered-output logic.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      load_done_d   = 1'b0;
      inst_valid_d  = 1'b0;
      fetch_fault_d = 1'b0;
      instr_d       = instr_q;
      mem_we        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_start) begin
               state_d = ST_LOAD;
               ptr_d   = '0;
            end
         end
         ST_LOAD: begin
            if (load_start) begin
               ptr_d = '0;
            end else if (load_valid) begin
               mem_we = 1'b1;
               if (load_last || (ptr_q == PTR_W'(DEPTH - 1))) begin
                  state_d     = ST_RUN;
                  ptr_d       = '0;
                  load_done_d = 1'b1;
               end else begin
                  ptr_d = ptr_q + PTR_W'(1);
               end
            end
         end
         ST_RUN: begin
            // A reload request takes priority over a same-cycle fetch.
            if (load_start) begin
               state_d = ST_LOAD;
               ptr_d   = '0;
            end else if (fetch_en) begin
               inst_valid_d  = 1'b1;
               fetch_fault_d = pc_bad;
               instr_d       = pc_bad ? NOP_WORD : mem_q[rd_idx];
            end
         end
         default: begin
            state_d = ST_IDLE;
            ptr_d   = '0;
         end
      endcase
      load_ready_d = (state_d == ST_LOAD);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         ptr_q         <= '0;
         load_ready_q  <= 1'b0;
         load_done_q   <= 1'b0;
         inst_valid_q  <= 1'b0;
         fetch_fault_q <= 1'b0;
         instr_q       <= NOP_WORD;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         load_ready_q  <= load_ready_d;
         load_done_q   <= load_done_d;
         inst_valid_q  <= inst_valid_d;
         fetch_fault_q <= fetch_fault_d;
         instr_q       <= instr_d;
      end
   end

   // Storage is deliberately not reset so a reset mid-load keeps written words.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[ptr_q] <= load_data;
      end
   end

   assign load_ready     = load_ready_q;
   assign load_done      = load_done_q;
   assign theInstruction = instr_q;
   assign inst_valid     = inst_valid_q;
   assign fetch_fault    = fetch_fault_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed self-checking bench for imem_loadable: load, fetch, fault, restart,
// priority and reset-retention scenarios with hand-computed expectations.
module tb_imem_loadable;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 64;
   localparam logic [31:0] NOP    = 32'hE1A00000;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              load_start = 1'b0;
   logic              load_valid = 1'b0;
   logic              load_last = 1'b0;
   logic [DATA_W-1:0] load_data = '0;
   logic              load_ready;
   logic              load_done;
   logic [31:0]       PC_Out = '0;
   logic              fetch_en = 1'b0;
   logic [DATA_W-1:0] theInstruction;
   logic              inst_valid;
   logic              fetch_fault;

   int vectors = 0;
   int miscompares = 0;

   imem_loadable #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
      .clk(clk), .reset(reset),
      .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
      .load_data(load_data), .load_ready(load_ready), .load_done(load_done),
      .PC_Out(PC_Out), .fetch_en(fetch_en), .theInstruction(theInstruction),
      .inst_valid(inst_valid), .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   // Advance past one rising edge; inputs change and outputs are sampled here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0; fetch_en = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++; if (load_ready !== 1'b0) begin miscompares++; $display("FAIL reset_load_ready got %b want 0", load_ready); end
      vectors++; if (load_done !== 1'b0) begin miscompares++; $display("FAIL reset_load_done got %b want 0", load_done); end
      vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL reset_inst_valid got %b want 0", inst_valid); end
      vectors++; if (fetch_fault !== 1'b0) begin miscompares++; $display("FAIL reset_fetch_fault got %b want 0", fetch_fault); end
      vectors++; if (theInstruction !== NOP) begin miscompares++; $display("FAIL reset_instr got %h want %h", theInstruction, NOP); end
      // Fetches in IDLE are ignored.
      PC_Out = 32'h0; fetch_en = 1'b1;
      tick();
      fetch_en = 1'b0;
      vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL idle_fetch_ignored got %b want 0", inst_valid); end
   endtask

   task automatic test_load_program();
      logic [31:0] prog [4];
      int ready_cycles;
      prog[0] = 32'hE0810002; prog[1] = 32'hE2400001;
      prog[2] = 32'hE1A00000; prog[3] = 32'hEAFFFFFE;
      ready_cycles = 0;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (load_ready === 1'b1) ready_cycles++;
         load_valid = 1'b1; load_data = prog[i]; load_last = (i == 3);
         tick();
      end
      idle_inputs();
      vectors++; if (ready_cycles !== 4) begin miscompares++; $display("FAIL load_ready_cycles got %0d want 4", ready_cycles); end
      vectors++; if (load_ready !== 1'b0) begin miscompares++; $display("FAIL load_ready_after got %b want 0", load_ready); end
      vectors++; if (load_done !== 1'b1) begin miscompares++; $display("FAIL load_done_pulse got %b want 1", load_done); end
      // Back-to-back fetches: one response per cycle.
      for (int i = 0; i < 4; i++) begin
         PC_Out = 32'(4 * i); fetch_en = 1'b1;
         tick();
         if (i == 0) begin
            vectors++; if (load_done !== 1'b0) begin miscompares++; $display("FAIL load_done_one_cycle got %b want 0", load_done); end
         end
         vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL fetch%0d_valid got %b want 1", i, inst_valid); end
         vectors++; if (theInstruction !== prog[i]) begin miscompares++; $display("FAIL fetch%0d_instr got %h want %h", i, theInstruction, prog[i]); end
         vectors++; if (fetch_fault !== 1'b0) begin miscompares++; $display("FAIL fetch%0d_fault got %b want 0", i, fetch_fault); end
      end
      fetch_en = 1'b0;
      tick();
      vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL nofetch_valid got %b want 0", inst_valid); end
      vectors++; if (theInstruction !== 32'hEAFFFFFE) begin miscompares++; $display("FAIL nofetch_hold got %h want eafffffe", theInstruction); end
   endtask

   task automatic test_fault();
      logic [31:0] bad_pc [3];
      bad_pc[0] = 32'h2; bad_pc[1] = 32'h100; bad_pc[2] = 32'h8000_0000;
      for (int i = 0; i < 3; i++) begin
         PC_Out = bad_pc[i]; fetch_en = 1'b1;
         tick();
         vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL fault%0d_valid got %b want 1", i, inst_valid); end
         vectors++; if (fetch_fault !== 1'b1) begin miscompares++; $display("FAIL fault%0d_flag got %b want 1", i, fetch_fault); end
         vectors++; if (theInstruction !== NOP) begin miscompares++; $display("FAIL fault%0d_instr got %h want %h", i, theInstruction, NOP); end
      end
      // A legal fetch right after a fault clears the flag.
      PC_Out = 32'h0;
      tick();
      fetch_en = 1'b0;
      vectors++; if (fetch_fault !== 1'b0) begin miscompares++; $display("FAIL after_fault_flag got %b want 0", fetch_fault); end
      vectors++; if (theInstruction !== 32'hE0810002) begin miscompares++; $display("FAIL after_fault_instr got %h want e0810002", theInstruction); end
      tick();
      vectors++; if (fetch_fault !== 1'b0) begin miscompares++; $display("FAIL idle_fault_clear got %b want 0", fetch_fault); end
   endtask

   task automatic test_full_load();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         // A bubble before word 10 must hold the pointer.
         if (i == 10) begin
            load_valid = 1'b0; load_data = 32'hBAD0BAD0;
            tick();
         end
         load_valid = 1'b1; load_last = 1'b0; load_data = 32'(i);
         tick();
      end
      idle_inputs();
      vectors++; if (load_done !== 1'b1) begin miscompares++; $display("FAIL full_load_done got %b want 1", load_done); end
      vectors++; if (load_ready !== 1'b0) begin miscompares++; $display("FAIL full_load_ready got %b want 0", load_ready); end
      PC_Out = 32'hFC; fetch_en = 1'b1;
      tick();
      vectors++; if (theInstruction !== 32'd63) begin miscompares++; $display("FAIL full_word63 got %h want 3f", theInstruction); end
      vectors++; if (fetch_fault !== 1'b0) begin miscompares++; $display("FAIL full_word63_fault got %b want 0", fetch_fault); end
      PC_Out = 32'h28;
      tick();
      fetch_en = 1'b0;
      vectors++; if (theInstruction !== 32'd10) begin miscompares++; $display("FAIL full_word10 got %h want a", theInstruction); end
   endtask

   task automatic test_restart();
      logic [31:0] exp_w [4];
      exp_w[0] = 32'hAAAA0000; exp_w[1] = 32'h22; exp_w[2] = 32'h33; exp_w[3] = 32'h3;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1; load_data = 32'(32'h11 * (i + 1));
         tick();
      end
      load_start = 1'b1; load_valid = 1'b1; load_data = 32'hDEADBEEF;
      tick();
      load_start = 1'b0;
      vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL restart_ready got %b want 1", load_ready); end
      load_data = 32'hAAAA0000; load_last = 1'b1;
      tick();
      idle_inputs();
      vectors++; if (load_done !== 1'b1) begin miscompares++; $display("FAIL restart_done got %b want 1", load_done); end
      for (int i = 0; i < 4; i++) begin
         PC_Out = 32'(4 * i); fetch_en = 1'b1;
         tick();
         vectors++; if (theInstruction !== exp_w[i]) begin miscompares++; $display("FAIL restart_word%0d got %h want %h", i, theInstruction, exp_w[i]); end
      end
      fetch_en = 1'b0;
   endtask

   task automatic test_load_vs_fetch();
      load_start = 1'b1; fetch_en = 1'b1; PC_Out = 32'h4;
      tick();
      idle_inputs();
      vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL prio_valid got %b want 0", inst_valid); end
      vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL prio_ready got %b want 1", load_ready); end
      vectors++; if (theInstruction !== 32'h3) begin miscompares++; $display("FAIL prio_instr_hold got %h want 3", theInstruction); end
      // In LOAD, fetches stay ignored.
      fetch_en = 1'b1;
      tick();
      fetch_en = 1'b0;
      vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL load_fetch_ignored got %b want 0", inst_valid); end
      load_valid = 1'b1; load_last = 1'b1; load_data = 32'hAAAA0000;
      tick();
      idle_inputs();
      vectors++; if (load_done !== 1'b1) begin miscompares++; $display("FAIL prio_reload_done got %b want 1", load_done); end
   endtask

   task automatic test_reset_midload();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      load_valid = 1'b1; load_data = 32'h77;
      tick();
      load_data = 32'h88;
      tick();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++; if (load_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_ready got %b want 0", load_ready); end
      vectors++; if (theInstruction !== NOP) begin miscompares++; $display("FAIL midrst_instr got %h want %h", theInstruction, NOP); end
      vectors++; if (load_done !== 1'b0) begin miscompares++; $display("FAIL midrst_done got %b want 0", load_done); end
      PC_Out = 32'h4; fetch_en = 1'b1;
      tick();
      fetch_en = 1'b0;
      vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_fetch_ignored got %b want 0", inst_valid); end
      // Reload only word 0 with its existing value; word 1 must survive.
      load_start = 1'b1;
      tick();
      load_start = 1'b0; load_valid = 1'b1; load_last = 1'b1; load_data = 32'h77;
      tick();
      idle_inputs();
      PC_Out = 32'h4; fetch_en = 1'b1;
      tick();
      vectors++; if (theInstruction !== 32'h88) begin miscompares++; $display("FAIL midrst_word1 got %h want 88", theInstruction); end
      PC_Out = 32'h0;
      tick();
      vectors++; if (theInstruction !== 32'h77) begin miscompares++; $display("FAIL midrst_word0 got %h want 77", theInstruction); end
      PC_Out = 32'h8;
      tick();
      fetch_en = 1'b0;
      vectors++; if (theInstruction !== 32'h33) begin miscompares++; $display("FAIL midrst_word2 got %h want 33", theInstruction); end
   endtask

   initial begin
      #2;
      test_reset();
      test_load_program();
      test_fault();
      test_full_load();
      test_restart();
      test_load_vs_fetch();
      test_reset_midload();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
